// File: rtl/display_arbiter_pkg.sv
// Shared types and constants for the display arbiter and its round-robin picker.
package display_arbiter_pkg;

    localparam int DIGITS  = 4;
    localparam int DIGIT_W = 4;
    localparam int DISP_W  = DIGITS * DIGIT_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_OPEN = 2'd2
    } state_e;

endpackage

// File: rtl/display_arbiter_rr_picker.sv
// Combinational round-robin picker: first requesting, non-excluded index
// searching last+1 .. last (mod N). Works for any N, not only powers of two.
module rr_picker #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     excl,
    input  logic [IDX_W-1:0] last,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Walk the N candidates starting just after 'last'; first hit wins.
    always_comb begin
        int c;
        logic [IDX_W-1:0] ci;
        found = 1'b0;
        idx   = '0;
        c     = 0;
        ci    = '0;
        for (int k = 1; k <= N; k++) begin
            c = int'(last) + k;
            if (c >= N) c = c - N;
            ci = IDX_W'(c);
            if (!found && req[ci] && !excl[ci]) begin
                found = 1'b1;
                idx   = ci;
            end
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Shares one 4-digit seven-segment display between N_REQ requesters:
// round-robin grant, each grant held for at least HOLD_TICKS prescaler ticks.
module display_arbiter
    import display_arbiter_pkg::*;
#(
    parameter int N_REQ      = 3,
    parameter int TICK_WIDTH = 16,
    parameter int HOLD_TICKS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [DISP_W*N_REQ-1:0]   req_digits,
    input  logic [DIGITS*N_REQ-1:0]   req_points,
    input  logic [DIGITS*N_REQ-1:0]   req_enables,
    output logic [N_REQ-1:0]          grant,
    output logic [DISP_W-1:0]         display,
    output logic [DIGITS-1:0]         points,
    output logic [DIGITS-1:0]         enable_digits,
    output logic                      switch_strobe
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int HC_W  = $clog2(HOLD_TICKS + 1);
    localparam logic [HC_W-1:0]  HC_LAST = HC_W'(HOLD_TICKS - 1);
    localparam logic [HC_W-1:0]  HC_MAX  = HC_W'(HOLD_TICKS);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

    state_e                state_q, state_d;
    logic [N_REQ-1:0]      grant_q, grant_d;
    logic [HC_W-1:0]       hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0]      rr_last_q, rr_last_d;
    logic [TICK_WIDTH-1:0] prescaler_q, prescaler_d;
    logic [DISP_W-1:0]     display_q, display_d;
    logic [DIGITS-1:0]     points_q, points_d;
    logic [DIGITS-1:0]     enables_q, enables_d;
    logic                  strobe_q, strobe_d;

    logic                  tick;
    logic                  owner_req;
    logic                  pick_found;
    logic [IDX_W-1:0]      pick_idx;
    logic [N_REQ-1:0]      pick_oh;

    assign tick      = &prescaler_q;
    assign owner_req = |(req & grant_q);

    // The current owner is always excluded; in IDLE grant_q is zero so nothing is.
    rr_picker #(.N(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req   (req),
        .excl  (grant_q),
        .last  (rr_last_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // One-hot form of the picker result.
    always_comb begin
        pick_oh = '0;
        for (int i = 0; i < N_REQ; i++)
            pick_oh[i] = (pick_idx == IDX_W'(i));
    end

    // Grant FSM: owner drop is checked before the tick so a drop discards it.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        hold_cnt_d = hold_cnt_q;
        rr_last_d  = rr_last_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d    = pick_oh;
                    hold_cnt_d = '0;
                    rr_last_d  = pick_idx;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!owner_req) begin
                    if (pick_found) begin
                        grant_d    = pick_oh;
                        hold_cnt_d = '0;
                        rr_last_d  = pick_idx;
                    end else begin
                        grant_d = '0;
                        state_d = ST_IDLE;
                    end
                end else if (tick) begin
                    if (hold_cnt_q != HC_MAX) hold_cnt_d = hold_cnt_q + 1'b1;
                    if (hold_cnt_q == HC_LAST) state_d = ST_OPEN;
                end
            end
            ST_OPEN: begin
                if (pick_found) begin
                    grant_d    = pick_oh;
                    hold_cnt_d = '0;
                    rr_last_d  = pick_idx;
                    state_d    = ST_HOLD;
                end else if (!owner_req) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath: live fields of the registered owner, zeros when idle; prescaler and strobe.
    always_comb begin
        display_d   = '0;
        points_d    = '0;
        enables_d   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                display_d = display_d | req_digits[DISP_W*i +: DISP_W];
                points_d  = points_d  | req_points[DIGITS*i +: DIGITS];
                enables_d = enables_d | req_enables[DIGITS*i +: DIGITS];
            end
        end
        strobe_d    = (grant_d != grant_q);
        prescaler_d = prescaler_q + 1'b1;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            hold_cnt_q  <= '0;
            rr_last_q   <= LAST_RST;
            prescaler_q <= '0;
            display_q   <= '0;
            points_q    <= '0;
            enables_q   <= '0;
            strobe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            hold_cnt_q  <= hold_cnt_d;
            rr_last_q   <= rr_last_d;
            prescaler_q <= prescaler_d;
            display_q   <= display_d;
            points_q    <= points_d;
            enables_q   <= enables_d;
            strobe_q    <= strobe_d;
        end
    end

    assign grant         = grant_q;
    assign display       = display_q;
    assign points        = points_q;
    assign enable_digits = enables_q;
    assign switch_strobe = strobe_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter (N_REQ=3, tick every 4 clks, HOLD_TICKS=2).
// Edge numbering: E0 is the first edge after reset release; ticks land on E(4m+3).
module tb_display_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [47:0] req_digits;
    logic [11:0] req_points;
    logic [11:0] req_enables;
    logic [2:0]  grant;
    logic [15:0] display;
    logic [3:0]  points;
    logic [3:0]  enable_digits;
    logic        switch_strobe;

    int checks   = 0;
    int failures = 0;
    int cyc      = -1;

    display_arbiter #(.N_REQ(3), .TICK_WIDTH(2), .HOLD_TICKS(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_digits    (req_digits),
        .req_points    (req_points),
        .req_enables   (req_enables),
        .grant         (grant),
        .display       (display),
        .points        (points),
        .enable_digits (enable_digits),
        .switch_strobe (switch_strobe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Hand-derived grant schedule for the req=3'b111 run starting at E35.
    function automatic logic [2:0] exp_g4(input int c);
        if (c < 35)      return 3'b000;
        else if (c < 44) return 3'b001;
        else if (c < 52) return 3'b010;
        else if (c < 60) return 3'b100;
        else             return 3'b001;
    endfunction

    function automatic logic [15:0] disp_of(input logic [2:0] g);
        case (g)
            3'b001:  return 16'hA0A0;
            3'b010:  return 16'h1234;
            3'b100:  return 16'hCCCC;
            default: return 16'h0000;
        endcase
    endfunction

    initial begin
        reset       = 1'b1;
        req         = 3'b000;
        req_digits  = {16'hCCCC, 16'h1234, 16'hA0A0};
        req_points  = {4'h4, 4'h5, 4'h6};
        req_enables = {4'hC, 4'hF, 4'h3};
        repeat (3) @(posedge clk);
        #1;

        // 1: reset values, then idle with no requests
        chk("rst_grant",   grant, 3'b000);
        chk("rst_display", display, 16'h0);
        chk("rst_points",  points, 4'h0);
        chk("rst_enables", enable_digits, 4'h0);
        chk("rst_strobe",  switch_strobe, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_grant",   grant, 3'b000);
            chk("idle_enables", enable_digits, 4'h0);
            chk("idle_strobe",  switch_strobe, 1'b0);
        end

        // 2: single requester 1 from IDLE (E20 grant, E21 data)
        req = 3'b010;
        step();
        chk("t2_grant",   grant, 3'b010);
        chk("t2_strobe",  switch_strobe, 1'b1);
        chk("t2_disp0",   display, 16'h0);
        step();
        chk("t2_display", display, 16'h1234);
        chk("t2_points",  points, 4'h5);
        chk("t2_enables", enable_digits, 4'hF);
        chk("t2_strobe1", switch_strobe, 1'b0);
        req = 3'b000;
        step();
        chk("t2_drop_grant",  grant, 3'b000);
        chk("t2_drop_strobe", switch_strobe, 1'b1);
        step();
        chk("t2_drop_disp",   display, 16'h0);
        chk("t2_drop_en",     enable_digits, 4'h0);
        chk("t2_drop_strobe1", switch_strobe, 1'b0);

        // 3: owner 0 holds against req[2] for 2 ticks (E24..E31), switch at E32
        req = 3'b001;
        step();
        chk("t3_grant0",  grant, 3'b001);
        chk("t3_strobe0", switch_strobe, 1'b1);
        req = 3'b101;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("t3_hold_grant",  grant, 3'b001);
            chk("t3_hold_strobe", switch_strobe, 1'b0);
            chk("t3_hold_disp",   display, 16'hA0A0);
        end
        step();
        chk("t3_switch_grant",  grant, 3'b100);
        chk("t3_switch_strobe", switch_strobe, 1'b1);
        req = 3'b000;
        step();
        chk("t3_idle_grant", grant, 3'b000);
        step();
        chk("t3_idle_disp",  display, 16'h0);

        // 4: all requesting; rotation 001 -> 010 -> 100 -> 001 (E35..E60)
        req = 3'b111;
        for (int c = 35; c <= 60; c++) begin
            step();
            chk("t4_cyc",     cyc, c);
            chk("t4_grant",   grant, exp_g4(c));
            chk("t4_strobe",  switch_strobe, exp_g4(c) != exp_g4(c - 1));
            chk("t4_display", display, disp_of(exp_g4(c - 1)));
        end

        // 5a: owner drops in HOLD with nobody else waiting
        req = 3'b000;
        step();
        chk("t5_drop_grant",  grant, 3'b000);
        chk("t5_drop_strobe", switch_strobe, 1'b1);
        step();
        chk("t5_drop_disp",   display, 16'h0);
        chk("t5_drop_en",     enable_digits, 4'h0);
        chk("t5_drop_pts",    points, 4'h0);

        // 5b: owner 0 drops while req[1] is up -> direct hand-over
        req = 3'b001;
        step();
        chk("t5_own_grant", grant, 3'b001);
        req = 3'b010;
        step();
        chk("t5_hand_grant",  grant, 3'b010);
        chk("t5_hand_strobe", switch_strobe, 1'b1);
        step();
        chk("t5_hand_disp",   display, 16'h1234);

        // 6: reset while requester 2 owns the display
        req = 3'b100;
        step();
        chk("t6_grant2", grant, 3'b100);
        step();
        chk("t6_disp2",  display, 16'hCCCC);
        chk("t6_en2",    enable_digits, 4'hC);
        reset = 1'b1;
        req   = 3'b111;
        step();
        chk("t6_rst_grant",   grant, 3'b000);
        chk("t6_rst_display", display, 16'h0);
        chk("t6_rst_points",  points, 4'h0);
        chk("t6_rst_enables", enable_digits, 4'h0);
        chk("t6_rst_strobe",  switch_strobe, 1'b0);
        reset = 1'b0;
        step();
        chk("t6_first_grant",  grant, 3'b001);
        chk("t6_first_strobe", switch_strobe, 1'b1);
        step();
        chk("t6_first_disp",   display, 16'hA0A0);
        chk("t6_first_pts",    points, 4'h6);
        chk("t6_first_en",     enable_digits, 4'h3);
        chk("t6_first_strobe1", switch_strobe, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
